// File: rtl/mole_scheduler_pkg.sv
// Shared encodings for the whack-a-mole datapath: difficulty levels, scheduler
// states and the mole-picker LFSR polynomial.
package mole_scheduler_pkg;

  typedef enum logic [1:0] {
    DIFF_EASY   = 2'b00,
    DIFF_MED    = 2'b01,
    DIFF_HARD   = 2'b10,
    DIFF_EXPERT = 2'b11
  } diff_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_UP    = 2'd2,
    ST_FLASH = 2'd3
  } sched_state_e;

  localparam int LFSR_W = 16;
  // Galois right-shift mask for x^16 + x^14 + x^13 + x^11
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  localparam int MS_W = 16;

endpackage

// File: rtl/whack_lfsr.sv
// Free-running 16-bit Galois LFSR used to pick moles; advances every cycle.
// A zero seed is replaced by 1 so the register can never lock up.
module whack_lfsr
  import mole_scheduler_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rand_byte
);

  localparam logic [LFSR_W-1:0] SAFE_SEED = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SAFE_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rand_byte = lfsr_q[7:0];

endmodule

// File: rtl/mole_scheduler.sv
// Mole sequencer: gap -> lit mole -> hit flash, judging whacks into one-cycle pulses.
// Whack-to-hit_pulse latency is 2 cycles; dropping enable returns to IDLE next cycle.
module mole_scheduler
  import mole_scheduler_pkg::*;
#(
  parameter int NUM_MOLES    = 4,
  parameter int TICK_DIV     = 100000,
  parameter int UP_MS_EASY   = 1500,
  parameter int UP_MS_MED    = 1000,
  parameter int UP_MS_HARD   = 600,
  parameter int UP_MS_EXPERT = 400,
  parameter int GAP_MS       = 300,
  parameter int FLASH_MS     = 200,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [1:0]                   difficulty_level,
  input  logic [NUM_MOLES-1:0]         btn_whack,
  output logic [NUM_MOLES-1:0]         mole_out,
  output logic [$clog2(NUM_MOLES)-1:0] active_idx,
  output logic                         hit_pulse,
  output logic                         timeout_pulse,
  output logic                         wrong_pulse,
  output logic [1:0]                   sched_state
);

  localparam int IW = $clog2(NUM_MOLES);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef logic [MS_W-1:0] ms_t;

  sched_state_e         state_q, state_d;
  logic [PW-1:0]        pre_q, pre_d;
  ms_t                  ms_q, ms_d;
  logic [NUM_MOLES-1:0] btn_q, btn_prev_q, rise, active_oh;
  logic [IW-1:0]        idx_q, idx_d, pick;
  logic                 hit_q, hit_d, to_q, to_d, wrong_q, wrong_d;
  logic [7:0]           rand_byte, pick_raw;
  logic                 tick, expire, load;
  ms_t                  load_ms, up_ms;

  whack_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .rand_byte (rand_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pre_q      <= '0;
      ms_q       <= '0;
      btn_q      <= '0;
      btn_prev_q <= '0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      to_q       <= 1'b0;
      wrong_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      ms_q       <= ms_d;
      btn_q      <= btn_whack;
      btn_prev_q <= btn_q;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      to_q       <= to_d;
      wrong_q    <= wrong_d;
    end
  end

  always_comb begin
    rise      = btn_q & ~btn_prev_q;
    active_oh = NUM_MOLES'(1) << idx_q;
    tick      = (pre_q == PW'(TICK_DIV - 1));
    expire    = tick && (ms_q == '0);

    case (diff_e'(difficulty_level))
      DIFF_EASY: up_ms = ms_t'(UP_MS_EASY);
      DIFF_MED:  up_ms = ms_t'(UP_MS_MED);
      DIFF_HARD: up_ms = ms_t'(UP_MS_HARD);
      default:   up_ms = ms_t'(UP_MS_EXPERT);
    endcase

    // Never light the same mole twice in a row: bump to the next index on a repeat.
    pick_raw = rand_byte % 8'(NUM_MOLES);
    if (pick_raw[IW-1:0] != idx_q) begin
      pick = pick_raw[IW-1:0];
    end else if (pick_raw == 8'(NUM_MOLES - 1)) begin
      pick = '0;
    end else begin
      pick = pick_raw[IW-1:0] + IW'(1);
    end

    state_d = state_q;
    idx_d   = idx_q;
    hit_d   = 1'b0;
    to_d    = 1'b0;
    wrong_d = 1'b0;
    load    = 1'b0;
    load_ms = ms_t'(GAP_MS);
    pre_d   = tick ? '0 : pre_q + PW'(1);
    ms_d    = (tick && ms_q != '0) ? ms_q - ms_t'(1) : ms_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_GAP;
        load    = 1'b1;
      end
      ST_GAP: begin
        if (expire) begin
          state_d = ST_UP;
          idx_d   = pick;
          load    = 1'b1;
          load_ms = up_ms;
        end
      end
      ST_UP: begin
        if (|(rise & active_oh)) begin
          hit_d   = 1'b1;
          state_d = ST_FLASH;
          load    = 1'b1;
          load_ms = ms_t'(FLASH_MS);
        end else begin
          wrong_d = |(rise & ~active_oh);
          if (expire) begin
            to_d    = 1'b1;
            state_d = ST_GAP;
            load    = 1'b1;
          end
        end
      end
      default: begin
        if (expire) begin
          state_d = ST_GAP;
          load    = 1'b1;
        end
      end
    endcase

    if (load) begin
      pre_d = '0;
      ms_d  = load_ms - ms_t'(1);
    end

    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = idx_q;
      hit_d   = 1'b0;
      to_d    = 1'b0;
      wrong_d = 1'b0;
      pre_d   = '0;
    end
  end

  always_comb begin
    case (state_q)
      ST_UP:    mole_out = active_oh;
      ST_FLASH: mole_out = '1;
      default:  mole_out = '0;
    endcase
  end

  assign active_idx    = idx_q;
  assign hit_pulse     = hit_q;
  assign timeout_pulse = to_q;
  assign wrong_pulse   = wrong_q;
  assign sched_state   = state_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed scenarios plus a randomized soak, checked every cycle against a
// phase/countdown reference model of the scheduler.
module tb_mole_scheduler;

  localparam int N      = 4;
  localparam int TD     = 4;
  localparam int GAP    = 2;
  localparam int EASY   = 5;
  localparam int MED    = 4;
  localparam int HARD   = 3;
  localparam int EXPERT = 2;
  localparam int FLASH  = 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b1;
  logic         enable = 1'b0;
  logic [1:0]   diff   = 2'b00;
  logic [N-1:0] btn    = '0;

  logic [N-1:0] mole_out;
  logic [1:0]   active_idx;
  logic         hit_pulse, timeout_pulse, wrong_pulse;
  logic [1:0]   sched_state;

  mole_scheduler #(
    .NUM_MOLES(N), .TICK_DIV(TD), .UP_MS_EASY(EASY), .UP_MS_MED(MED),
    .UP_MS_HARD(HARD), .UP_MS_EXPERT(EXPERT), .GAP_MS(GAP), .FLASH_MS(FLASH),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .difficulty_level(diff),
    .btn_whack(btn), .mole_out(mole_out), .active_idx(active_idx),
    .hit_pulse(hit_pulse), .timeout_pulse(timeout_pulse),
    .wrong_pulse(wrong_pulse), .sched_state(sched_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: phase + cycles left in phase, button sample history.
  int           m_st, m_prev_st, m_left, m_idx;
  bit           m_hit, m_to, m_wr;
  logic [15:0]  m_lfsr;
  logic [N-1:0] m_h1, m_h2;

  int hits = 0, tos = 0, wrongs = 0, up_run = 0, last_up_len = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic int up_cycles(input logic [1:0] d);
    case (d)
      2'd0:    return EASY * TD;
      2'd1:    return MED * TD;
      2'd2:    return HARD * TD;
      default: return EXPERT * TD;
    endcase
  endfunction

  function automatic logic [N-1:0] exp_mole();
    logic [N-1:0] one;
    one = N'(1);
    if (m_st == 2) return one << m_idx;
    if (m_st == 3) return '1;
    return '0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_prev_st = 0; m_left = 0; m_idx = 0;
    m_hit = 0; m_to = 0; m_wr = 0;
    m_lfsr = SEED; m_h1 = '0; m_h2 = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] edges, act, one;
    int pick;
    one   = N'(1);
    edges = m_h1 & ~m_h2;
    act   = one << m_idx;
    m_prev_st = m_st;
    m_hit = 0; m_to = 0; m_wr = 0;
    if (!enable) begin
      m_st = 0;
    end else begin
      case (m_st)
        0: begin m_st = 1; m_left = GAP * TD; end
        1: begin
          if (m_left == 1) begin
            pick = int'(m_lfsr[7:0]) % N;
            if (pick == m_idx) pick = (pick + 1) % N;
            m_idx = pick; m_st = 2; m_left = up_cycles(diff);
          end else m_left--;
        end
        2: begin
          if ((edges & act) != '0) begin
            m_hit = 1; m_st = 3; m_left = FLASH * TD;
          end else begin
            if ((edges & ~act) != '0) m_wr = 1;
            if (m_left == 1) begin m_to = 1; m_st = 1; m_left = GAP * TD; end
            else m_left--;
          end
        end
        default: begin
          if (m_left == 1) begin m_st = 1; m_left = GAP * TD; end
          else m_left--;
        end
      endcase
    end
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    m_h2 = m_h1;
    m_h1 = btn;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("mole_out", 32'(mole_out), 32'(exp_mole()));
    chk("sched_state", 32'(sched_state), m_st);
    chk("active_idx", 32'(active_idx), m_idx);
    chk("hit_pulse", 32'(hit_pulse), 32'(m_hit));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(m_to));
    chk("wrong_pulse", 32'(wrong_pulse), 32'(m_wr));
    if (hit_pulse) hits++;
    if (timeout_pulse) tos++;
    if (wrong_pulse) wrongs++;
    if (sched_state == 2'd2) up_run++;
    else if (up_run > 0) begin last_up_len = up_run; up_run = 0; end
  endtask

  task automatic wait_up_entry();
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (m_st == 2 && m_prev_st != 2) return;
    end
    n_cmp++; n_fail++;
    $error("FAIL wait_up: no UP entry within 400 cycles");
  endtask

  task automatic run_out_up();
    for (int i = 0; i < 100 && sched_state == 2'd2; i++) cyc();
  endtask

  initial begin
    int gap_len, up_len, lat, flash_len, h0, t0, w0, p0, prev_i, cur, repeats;
    logic [N-1:0] seen, one;
    one = N'(1);

    // Power-on reset and idle hold.
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("por_mole", 32'(mole_out), 0);
    chk("por_state", 32'(sched_state), 0);
    chk("por_pulses", {29'd0, hit_pulse, timeout_pulse, wrong_pulse}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) cyc();

    // First gap / up window with no buttons.
    enable = 1'b1;
    cyc();
    gap_len = 0;
    for (int i = 0; i < 100 && sched_state == 2'd1; i++) begin gap_len++; cyc(); end
    chk("first_gap_len", gap_len, GAP * TD);
    up_len = 0;
    for (int i = 0; i < 100 && sched_state == 2'd2; i++) begin up_len++; cyc(); end
    chk("first_up_len", up_len, EASY * TD);
    chk("first_timeout", 32'(timeout_pulse), 1);

    // 50 consecutive moles: no repeats, every index used.
    repeats = 0; seen = '0; prev_i = -1;
    for (int k = 0; k < 50; k++) begin
      wait_up_entry();
      cur = int'(active_idx);
      if (cur == prev_i) repeats++;
      seen = seen | (one << cur);
      prev_i = cur;
    end
    chk("mole_repeats", repeats, 0);
    chk("moles_seen", 32'(seen), 32'hF);

    // Correct whack held for 30 cycles.
    wait_up_entry();
    repeat (4) cyc();
    h0 = hits; t0 = tos;
    btn = one << m_idx;
    lat = 0;
    for (int i = 0; i < 10; i++) begin cyc(); lat++; if (hit_pulse) break; end
    chk("hit_latency", lat, 2);
    flash_len = 0;
    for (int i = 0; i < 20 && sched_state == 2'd3; i++) begin
      chk("flash_all_on", 32'(mole_out), 32'hF);
      flash_len++; cyc();
    end
    chk("flash_len", flash_len, FLASH * TD);
    repeat (30 - lat - flash_len) cyc();
    btn = '0;
    chk("hit_once", hits - h0, 1);
    chk("hit_no_timeout", tos - t0, 0);

    // Wrong whack mid-window.
    wait_up_entry();
    w0 = wrongs; t0 = tos;
    repeat (3) cyc();
    btn = one << ((m_idx + 1) % N);
    repeat (2) cyc();
    btn = '0;
    run_out_up();
    chk("wrong_once", wrongs - w0, 1);
    chk("wrong_up_len", last_up_len, EASY * TD);
    chk("wrong_timeout", tos - t0, 1);

    // Active edge lands on the expiry cycle.
    wait_up_entry();
    h0 = hits; t0 = tos;
    repeat (18) cyc();
    btn = one << m_idx;
    repeat (2) cyc();
    btn = '0;
    chk("expiry_hit", hits - h0, 1);
    chk("expiry_no_timeout", tos - t0, 0);

    // Active and wrong edges together.
    wait_up_entry();
    h0 = hits; w0 = wrongs;
    repeat (3) cyc();
    btn = (one << m_idx) | (one << ((m_idx + 2) % N));
    repeat (3) cyc();
    btn = '0;
    chk("both_hit", hits - h0, 1);
    chk("both_no_wrong", wrongs - w0, 0);

    // Difficulty change applies from the next window.
    wait_up_entry();
    repeat (5) cyc();
    diff = 2'b11;
    run_out_up();
    chk("cur_window_len", last_up_len, EASY * TD);
    wait_up_entry();
    run_out_up();
    chk("next_window_len", last_up_len, EXPERT * TD);
    diff = 2'b00;

    // Drop enable mid-window.
    wait_up_entry();
    repeat (3) cyc();
    p0 = hits + tos + wrongs;
    enable = 1'b0;
    cyc();
    chk("drop_mole", 32'(mole_out), 0);
    chk("drop_state", 32'(sched_state), 0);
    repeat (4) cyc();
    chk("drop_no_pulse", hits + tos + wrongs - p0, 0);
    enable = 1'b1;

    // Reset asserted mid-UP.
    wait_up_entry();
    repeat (5) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mole", 32'(mole_out), 0);
    chk("rst_state", 32'(sched_state), 0);
    chk("rst_idx", 32'(active_idx), 0);
    chk("rst_pulses", {29'd0, hit_pulse, timeout_pulse, wrong_pulse}, 0);
    model_reset();
    enable = 1'b0;
    up_run = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) cyc();
    chk("post_rst_idle", 32'(sched_state), 0);

    // Randomized soak.
    enable = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      cyc();
      for (int b = 0; b < N; b++) if ($urandom_range(0, 9) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 49) == 0) diff = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
Sequences the mole display during the PLAYING phase. Driven by the game controller's enable_mole_ctrl and difficulty_level outputs, it picks a pseudo-random mole and holds it up for a difficulty-dependent window. It judges the player's whacks and emits the hit_pulse and timeout_pulse that the game controller and score counter consume. It sits between the debounced button inputs and the mole LEDs.

Parameters:
NUM_MOLES, 4, number of moles/buttons (2..8)
TICK_DIV, 100000, clk cycles per 1 ms timing tick
UP_MS_EASY, 1500, mole up-time for difficulty 2'b00 (ms)
UP_MS_MED, 1000, up-time for 2'b01
UP_MS_HARD, 600, up-time for 2'b10
UP_MS_EXPERT, 400, up-time for 2'b11
GAP_MS, 300, dark time between moles (ms)
FLASH_MS, 200, hit-feedback flash duration (ms)
LFSR_SEED, 16'hACE1, LFSR reset value (0 is replaced by 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; high while the game is playing
difficulty_level  in  2  00 easy, 01 med, 10 hard, 11 expert
btn_whack  in  NUM_MOLES  debounced, synchronized button levels
mole_out  out  NUM_MOLES  mole LED drive
active_idx  out  clog2(NUM_MOLES)  index of the current/last mole
hit_pulse  out  1  one-cycle correct whack
timeout_pulse  out  1  one-cycle mole expired unhit
wrong_pulse  out  1  one-cycle whack on a non-active mole
sched_state  out  2  IDLE=0, GAP=1, UP=2, FLASH=3

Behaviour:
- Reset: all outputs 0, state IDLE, LFSR=LFSR_SEED, button history regs 0, prev mole = 0.
- Edge detect: per-bit rise = btn_whack & ~btn_prev, with btn_prev registered every cycle. A held button produces exactly one edge.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Free-runs every cycle in all states. Never zero.
- Timer: prescaler counts 0..TICK_DIV-1 and emits a tick. A ms counter is loaded with D-1 and the prescaler is cleared on state entry. On a tick with ms counter==0 the timer expires; otherwise the counter decrements. Each timed state lasts exactly D*TICK_DIV cycles.
- IDLE: mole_out=0, no pulses. enable=1 -> GAP with D=GAP_MS.
- GAP: mole_out=0. On expiry:
  - idx = LFSR[7:0] mod NUM_MOLES; if idx==prev mole, idx=(idx+1) mod NUM_MOLES.
  - Latch idx into active_idx and the up-time from difficulty_level sampled this cycle.
  - Go to UP.
- UP: mole_out = one-hot(active_idx).
  - Edge on the active bit -> hit_pulse, go to FLASH with D=FLASH_MS.
  - Else on expiry -> timeout_pulse, go to GAP.
  - Edge on any other bit -> wrong_pulse, stay in UP; the timer is unaffected.
- FLASH: mole_out = all ones. On expiry go to GAP. Button edges are ignored.
- Pulses are registered: high exactly one cycle, asserted in the same cycle sched_state leaves UP (hit/timeout) or one cycle after the edge is detected (wrong). Latency from btn_whack first sampled high to hit_pulse is 2 cycles.
- Simultaneous events:
  - Hit and expiry in the same cycle: hit wins, no timeout.
  - Hit and wrong edge in the same cycle: hit only.
  - Multiple wrong edges: a single wrong_pulse.
- enable=0 in any state: IDLE on the next cycle, mole_out=0, no pulse emitted, prescaler cleared. active_idx holds its value.
- difficulty_level changes take effect only at the next GAP->UP latch.
- prev mole updates on each GAP->UP transition.

Decomposition:
- Shared package: difficulty encodings (shared with the game controller), sched_state encodings, LFSR polynomial/width constants.
- One sub-module: whack_lfsr (16-bit Galois LFSR, seed parameter, zero-seed guard).
- The timer/prescaler stays inline.

Test Plan:
All scenarios use TICK_DIV=4, GAP_MS=2, UP_MS_EASY=5, UP_MS_EXPERT=2, FLASH_MS=1, NUM_MOLES=4.
- Reset asserted mid-UP -> all outputs 0 and sched_state=0 immediately; after release, stays in IDLE while enable=0.
- enable=1, difficulty 00, no buttons -> mole_out=0 for 8 cycles, one-hot for 20 cycles, then one timeout_pulse. 50 consecutive moles: none repeats its predecessor, all 4 indices appear.
- Press the active button 5 cycles into UP, hold it 30 cycles -> one hit_pulse 2 cycles after the press, mole_out=4'b1111 for 4 cycles, then GAP, no timeout_pulse, no second hit.
- Press a wrong button during UP -> one wrong_pulse; mole stays lit; timeout still occurs at the original 20-cycle mark.
- Active button edge aligned to the expiry cycle -> hit_pulse only. Wrong and active edges in the same cycle -> hit_pulse only.
- Change difficulty 00->11 mid-UP -> current window remains 20 cycles, next window is 8 cycles. Drop enable mid-UP -> mole_out=0 next cycle, no pulses.
